// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings and default latencies for the E-stage multiply/divide unit.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MDOP_NONE  = 4'd0,
        MDOP_MULT  = 4'd1,
        MDOP_MULTU = 4'd2,
        MDOP_DIV   = 4'd3,
        MDOP_DIVU  = 4'd4,
        MDOP_MFHI  = 4'd5,
        MDOP_MFLO  = 4'd6,
        MDOP_MTHI  = 4'd7,
        MDOP_MTLO  = 4'd8
    } md_op_e;

    localparam int unsigned MDU_MULT_CYCLES = 5;
    localparam int unsigned MDU_DIV_CYCLES  = 10;

    // Codes 1..4 launch a multi-cycle operation; 9..15 fall through as NONE.
    function automatic logic md_is_start(input logic [3:0] op);
        return (op >= MDOP_MULT) && (op <= MDOP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit: owns HI/LO, sequences fixed-latency mult/div with a
// down-counter, and raises the stall that holds D-stage md instructions.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdOp_E,
    input  logic [31:0] srcA_E,
    input  logic [31:0] srcB_E,
    input  logic        mdUse_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] mdOut_E
);

    logic [3:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] pend_hi_q, pend_lo_q;
    logic        pend_we_q;

    logic        start_E;
    logic        is_mul;
    logic [31:0] res_hi, res_lo;
    logic        res_we;
    logic [63:0] prod_s, prod_u;

    assign start_E = md_is_start(mdOp_E);
    assign is_mul  = (mdOp_E == MDOP_MULT) || (mdOp_E == MDOP_MULTU);
    assign busy    = (cnt_q != 4'd0);
    assign stall_md = mdUse_D & (busy | start_E);

    // Full 64-bit products; operands are widened explicitly so signedness is unambiguous.
    assign prod_s = $signed({{32{srcA_E[31]}}, srcA_E}) * $signed({{32{srcB_E[31]}}, srcB_E});
    assign prod_u = {32'd0, srcA_E} * {32'd0, srcB_E};

    // Result arithmetic; zero divisor and INT_MIN/-1 are steered away from the divider.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_we = 1'b1;
        unique case (mdOp_E)
            MDOP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MDOP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MDOP_DIV: begin
                if (srcB_E == 32'd0) begin
                    res_we = 1'b0;
                end else if (srcA_E == 32'h8000_0000 && srcB_E == 32'hFFFF_FFFF) begin
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = $signed(srcA_E) / $signed(srcB_E);
                    res_hi = $signed(srcA_E) % $signed(srcB_E);
                end
            end
            MDOP_DIVU: begin
                if (srcB_E == 32'd0) begin
                    res_we = 1'b0;
                end else begin
                    res_lo = srcA_E / srcB_E;
                    res_hi = srcA_E % srcB_E;
                end
            end
            default: res_we = 1'b0;
        endcase
    end

    // Counter, pending result and HI/LO; MTHI/MTLO are last so they beat a same-edge commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
        end else begin
            if (cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
                if (cnt_q == 4'd1 && pend_we_q) begin
                    hi_q <= pend_hi_q;
                    lo_q <= pend_lo_q;
                end
            end else if (start_E) begin
                cnt_q     <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                pend_hi_q <= res_hi;
                pend_lo_q <= res_lo;
                pend_we_q <= res_we;
            end
            if (mdOp_E == MDOP_MTHI) hi_q <= srcA_E;
            if (mdOp_E == MDOP_MTLO) lo_q <= srcA_E;
        end
    end

    // Only committed HI/LO are ever visible to MFHI/MFLO.
    always_comb begin
        mdOut_E = 32'd0;
        if (mdOp_E == MDOP_MFHI) mdOut_E = hi_q;
        else if (mdOp_E == MDOP_MFLO) mdOut_E = lo_q;
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed plus randomized bench for mdu_ctrl with a high-level HI/LO model.
module tb_mdu_ctrl;

    localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2,
                           OP_DIV = 4'd3, OP_DIVU = 4'd4, OP_MFHI = 4'd5,
                           OP_MFLO = 4'd6, OP_MTHI = 4'd7, OP_MTLO = 4'd8;
    localparam int N_MUL = 5;
    localparam int N_DIV = 10;

    logic        clk, reset;
    logic [3:0]  mdOp_E;
    logic [31:0] srcA_E, srcB_E;
    logic        mdUse_D;
    logic        busy, stall_md;
    logic [31:0] mdOut_E;

    int passed = 0;
    int total  = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_ctrl dut (
        .clk(clk), .reset(reset), .mdOp_E(mdOp_E), .srcA_E(srcA_E), .srcB_E(srcB_E),
        .mdUse_D(mdUse_D), .busy(busy), .stall_md(stall_md), .mdOut_E(mdOut_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference semantics straight from the ISA: 64-bit arithmetic, divide-by-zero leaves HI/LO.
    task automatic model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint    sa, sb, q, r;
        logic [63:0] p;
        case (op)
            OP_MULT: begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                p = 64'(sa * sb);
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            OP_DIV: if (b != 0) begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                q = sa / sb; r = sa % sb;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            OP_DIVU: if (b != 0) begin
                m_lo = a / b; m_hi = a % b;
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // Launch a mult/div, watch every busy cycle, then read back HI and LO.
    task automatic do_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d);
        int n;
        logic [31:0] old_hi;
        n = (op == OP_MULT || op == OP_MULTU) ? N_MUL : N_DIV;
        old_hi = m_hi;
        @(posedge clk); #1;
        mdOp_E = op; srcA_E = a; srcB_E = b; mdUse_D = use_d;
        @(negedge clk);
        chk("start_busy", 32'(busy), 32'd0);
        chk("start_stall", 32'(stall_md), 32'(use_d));
        model_exec(op, a, b);
        @(posedge clk); #1;
        mdOp_E = OP_MFHI; srcA_E = $urandom; srcB_E = $urandom;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("busy_c%0d", i), 32'(busy), 32'd1);
            chk($sformatf("stall_c%0d", i), 32'(stall_md), 32'(use_d));
            chk($sformatf("midflight_c%0d", i), mdOut_E, old_hi);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_stall", 32'(stall_md), 32'd0);
        chk("hi_after", mdOut_E, m_hi);
        @(posedge clk); #1;
        mdOp_E = OP_MFLO;
        @(negedge clk);
        chk("lo_after", mdOut_E, m_lo);
        @(posedge clk); #1;
        mdOp_E = OP_NONE; mdUse_D = 1'b0;
    endtask

    // MTHI/MTLO followed immediately by the matching move-from.
    task automatic do_mt(input logic [3:0] op, input logic [31:0] v);
        @(posedge clk); #1;
        mdOp_E = op; srcA_E = v; mdUse_D = $urandom_range(0, 1);
        @(negedge clk);
        chk("mt_busy", 32'(busy), 32'd0);
        chk("mt_stall", 32'(stall_md), 32'd0);
        model_exec(op, v, 32'd0);
        @(posedge clk); #1;
        mdOp_E = (op == OP_MTHI) ? OP_MFHI : OP_MFLO;
        @(negedge clk);
        chk("mt_read", mdOut_E, (op == OP_MTHI) ? m_hi : m_lo);
        chk("mt_busy2", 32'(busy), 32'd0);
        @(posedge clk); #1;
        mdOp_E = OP_NONE; mdUse_D = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] op);
        @(posedge clk); #1;
        mdOp_E = op;
        @(negedge clk);
        chk("read", mdOut_E, (op == OP_MFHI) ? m_hi : m_lo);
        @(posedge clk); #1;
        mdOp_E = OP_NONE;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [4];
        sp[0] = 32'd0; sp[1] = 32'h8000_0000; sp[2] = 32'hFFFF_FFFF; sp[3] = 32'd1;
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    initial begin
        logic [3:0] op;
        reset = 1'b1; mdOp_E = OP_MFHI; srcA_E = 32'd5; srcB_E = 32'd3; mdUse_D = 1'b1;
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mfhi", mdOut_E, 32'd0);
        chk("rst_stall_nostart", 32'(stall_md), 32'd0);
        mdOp_E = OP_MULT; #1;
        chk("rst_stall_start", 32'(stall_md), 32'd1);
        mdOp_E = OP_NONE; mdUse_D = 1'b0;
        #20 reset = 1'b0;

        do_md(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
        do_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_md(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        do_mt(OP_MTHI, 32'h11);
        do_mt(OP_MTLO, 32'h22);
        do_md(OP_DIVU, 32'd7, 32'd0, 1'b1);
        do_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_mt(OP_MTLO, 32'h1234);
        chk("fixed_mult_hi_model", m_hi, 32'd0);

        // Abort a divide at its third busy cycle with HI/LO holding nonzero values.
        do_mt(OP_MTHI, 32'hAAAA_5555);
        @(posedge clk); #1;
        mdOp_E = OP_DIV; srcA_E = 32'd100; srcB_E = 32'd7;
        @(posedge clk); #1; mdOp_E = OP_NONE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_abort_busy", 32'(busy), 32'd1);
        reset = 1'b1; mdOp_E = OP_MFHI; #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", mdOut_E, 32'd0);
        mdOp_E = OP_MFLO; #1;
        chk("abort_lo", mdOut_E, 32'd0);
        mdOp_E = OP_NONE; #1 reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (N_DIV + 2) @(posedge clk);
        #1;
        chk("post_abort_busy", 32'(busy), 32'd0);
        do_read(OP_MFHI);
        do_read(OP_MFLO);

        for (int k = 0; k < 30; k++) begin
            op = 4'($urandom_range(1, 8));
            if (op <= OP_DIVU) do_md(op, pick(), pick(), 1'($urandom_range(0, 1)));
            else if (op >= OP_MTHI) do_mt(op, pick());
            else do_read(op);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit with its sequencing controller for the five-stage MIPS pipeline. It sits in the E stage beside the ALU and owns the HI/LO registers. It runs mult/multu/div/divu as fixed-latency multi-cycle operations with a down-counter, and handles mthi/mtlo/mfhi/mflo. It produces the stall request that holds a D-stage multiply/divide instruction while the unit is occupied.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu; legal range 1..15
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- mdOp_E  in  4  operation of the instruction currently in E; `MDOP_*` encoding
- srcA_E  in  32  forwarded rs value in E
- srcB_E  in  32  forwarded rt value in E
- mdUse_D  in  1  D-stage instruction is any of the 8 md instructions
- busy  out  1  multi-cycle operation in progress
- stall_md  out  1  stall request to the hazard unit
- mdOut_E  out  32  HI for MFHI, LO for MFLO, else 0; combinational

## Operation
- Operation encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. Values 9..15 are treated as NONE.
- start_E = mdOp_E in {1..4}. An E instruction occupies E for exactly one cycle, because stall clears E. The unit therefore sees each operation once.
- On a clock edge where start_E=1 and cnt==0:
  - pending{HI,LO} <= result computed from srcA_E/srcB_E.
  - cnt <= MULT_CYCLES or DIV_CYCLES.
- Arithmetic:
  - MULT: 64-bit signed product; HI = [63:32], LO = [31:0].
  - MULTU: same, unsigned.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - Divisor 0: the operation still takes DIV_CYCLES, but HI/LO are left unchanged (commit suppressed).
  - 0x80000000 / -1 (signed): LO=0x80000000, HI=0.
- Each edge with cnt!=0: cnt <= cnt-1. When cnt==1, HI/LO <= pending (unless suppressed).
- busy = (cnt != 0).
- MTHI/MTLO: HI or LO <= srcA_E on the edge, single cycle, no busy.
- MFHI/MFLO: read the committed HI/LO. A mid-flight result is never visible.
- stall_md = mdUse_D & (busy | start_E).
- start_E while cnt!=0 cannot occur because of stall_md. If it does, the unit ignores it: no restart and no pending overwrite.
- Simultaneous MTHI/MTLO and commit on the same edge cannot occur, because stall_md guarantees ordering. If it does, MTHI/MTLO wins.

## Timing
- Reset values: cnt=0, HI=0, LO=0, pending=0. Outputs after reset: busy=0, stall_md=mdUse_D & start_E, mdOut_E per mdOp_E (0 unless MFHI/MFLO).
- Reset mid-operation aborts the operation: cnt, HI and LO clear immediately, and no commit follows.
- Start sampled at the end of cycle t:
  - busy is high for cycles t+1 .. t+N.
  - HI/LO update at the end of cycle t+N.
  - An MFHI in E at cycle t+N+1 reads the new value.
- A D-stage md instruction in cycle t (with start in E) stalls cycles t .. t+N. It enters E in cycle t+N+1.
- MTHI at the end of cycle t is readable by an MFHI in E at cycle t+1.
- cnt is 4 bits wide.

## Structure
- `MDOP_*` encodings go in macro.v.
- The `MULT_CYCLES`/`DIV_CYCLES` defaults go in macro.v as `MDU_MULT_CYCLES` and `MDU_DIV_CYCLES`.
- No sub-module: result arithmetic is a combinational block using Verilog `*`, `/`, `%` with $signed.
- HI, LO, pending and cnt are local registers with asynchronous reset.
- The ctrl module adds the decode for mdOp and mdUse. hazard ORs stall_md into stall. The E-stage result mux selects mdOut_E for mfhi/mflo.

## Test plan
- MULT, srcA=0xFFFFFFFE (-2), srcB=3 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFHI afterwards returns 0xFFFFFFFF.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 with HI/LO preloaded to 0x11/0x22 -> 10 busy cycles, HI/LO remain 0x11/0x22.
- MULT in E with mdUse_D=1 -> stall_md high in the start cycle plus 5 busy cycles (6 total), low on the following cycle. mdUse_D=0 throughout -> stall_md never asserted.
- MTLO 0x1234 then MFLO in the next cycle -> mdOut_E=0x1234, busy stays 0.
- DIV started, reset pulsed at busy cycle 3 -> busy=0, HI=LO=0 immediately. No commit occurs at the original completion cycle.
